// File: rtl/mem_stage_dcache.sv
// MEM pipeline stage with MEM/WB register. Loads and stores are served from a
// direct-mapped, write-through, no-write-allocate cache of one-word lines.
// A small FSM talks to main memory over a level req / one-cycle ack handshake.
//
// Memory handshake: memReq is a level raised in the cycle the access is
// recognised and held until (and including) the cycle memAck is high. memWe,
// memAddr and memWData are valid whenever memReq is high. memAck while the
// FSM is not waiting in FILL/WRITE is ignored.
// dbg_state: 0=IDLE 1=FILL 2=WRITE 3=DONE.
module mem_stage_dcache #(
    parameter int IDX_BITS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ALUResult,
    input  logic [31:0] readData2,
    input  logic [4:0]  writeReg,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic        zeroFlag,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memAck,
    output logic        stall,
    output logic        PCSrc,
    output logic        cacheHit,
    output logic [31:0] readDataOut,
    output logic [31:0] ALUResultOut,
    output logic [4:0]  writeRegOut,
    output logic        RegWriteOut,
    output logic        MemToRegOut,
    output logic [1:0]  dbg_state
);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int LINES    = 1 << IDX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [31:0] fill_buf_q, fill_buf_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [4:0]  wr_reg_q, wr_reg_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;

    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic                is_read;
    logic                is_write;
    logic                hit;

    logic                arr_we;
    logic [31:0]         arr_data_d;
    logic                capture;
    logic [31:0]         load_data;

    assign idx      = ALUResult[IDX_BITS+1:2];
    assign tag      = ALUResult[31:IDX_BITS+2];
    // A combined read+write is a write; the read half is dropped.
    assign is_write = MemWrite;
    assign is_read  = MemRead & ~MemWrite;
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    assign cacheHit  = (MemRead | MemWrite) & hit;
    assign memAddr   = {ALUResult[31:2], 2'b00};
    assign memWData  = readData2;
    assign PCSrc     = Branch & zeroFlag & ~stall;
    assign dbg_state = state_q;

    assign readDataOut  = rd_data_q;
    assign ALUResultOut = alu_res_q;
    assign writeRegOut  = wr_reg_q;
    assign RegWriteOut  = reg_write_q;
    assign MemToRegOut  = mem_to_reg_q;

    // Next-state, handshake outputs, cache update and MEM/WB load decisions.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        fill_buf_d = fill_buf_q;
        arr_we     = 1'b0;
        arr_data_d = readData2;
        stall      = 1'b0;
        memReq     = 1'b0;
        memWe      = 1'b0;
        capture    = 1'b0;
        load_data  = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (is_write) begin
                    stall  = 1'b1;
                    memReq = 1'b1;
                    memWe  = 1'b1;
                    // Write-through: refresh the line only if it already holds this word.
                    arr_we  = hit;
                    state_d = S_WRITE;
                end else if (is_read && !hit) begin
                    stall   = 1'b1;
                    memReq  = 1'b1;
                    state_d = S_FILL;
                end else begin
                    capture   = 1'b1;
                    load_data = is_read ? data_q[idx] : 32'h0;
                end
            end
            S_FILL: begin
                stall  = 1'b1;
                memReq = 1'b1;
                if (memAck) begin
                    valid_d[idx] = 1'b1;
                    arr_we       = 1'b1;
                    arr_data_d   = memRData;
                    fill_buf_d   = memRData;
                    state_d      = S_DONE;
                end
            end
            S_WRITE: begin
                stall  = 1'b1;
                memReq = 1'b1;
                memWe  = 1'b1;
                if (memAck) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                // DONE: the held EX/MEM contents retire into MEM/WB.
                capture   = 1'b1;
                load_data = is_read ? fill_buf_q : 32'h0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // MEM/WB next values: full capture when not stalled, bubble otherwise.
    always_comb begin
        rd_data_d    = rd_data_q;
        alu_res_d    = alu_res_q;
        wr_reg_d     = wr_reg_q;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        if (capture) begin
            rd_data_d    = load_data;
            alu_res_d    = ALUResult;
            wr_reg_d     = writeReg;
            reg_write_d  = RegWrite;
            mem_to_reg_d = MemToReg;
        end
    end

    // State, valid bits, fill buffer and MEM/WB register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            fill_buf_q   <= 32'h0;
            rd_data_q    <= 32'h0;
            alu_res_q    <= 32'h0;
            wr_reg_q     <= 5'h0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            fill_buf_q   <= fill_buf_d;
            rd_data_q    <= rd_data_d;
            alu_res_q    <= alu_res_d;
            wr_reg_q     <= wr_reg_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (!reset && arr_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= arr_data_d;
        end
    end
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Bench for mem_stage_dcache: directed scenarios plus a randomized access
// stream, checked against a word-level memory model and a residency model.
module tb_mem_stage_dcache;
  logic        clock;
  logic        reset;
  logic [31:0] ALUResult;
  logic [31:0] readData2;
  logic [4:0]  writeReg;
  logic        MemRead, MemWrite, Branch, RegWrite, MemToReg, zeroFlag;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWData, memRData;
  logic        memAck;
  logic        stall, PCSrc, cacheHit;
  logic [31:0] readDataOut, ALUResultOut;
  logic [4:0]  writeRegOut;
  logic        RegWriteOut, MemToRegOut;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // Memory contents by word address; unwritten words read a fixed pattern.
  logic [31:0] mem_model [int];
  // Word address currently held by each cache index, -1 when none.
  int res_word [16];

  mem_stage_dcache dut (
    .clock(clock), .reset(reset), .ALUResult(ALUResult), .readData2(readData2),
    .writeReg(writeReg), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .zeroFlag(zeroFlag),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck), .stall(stall), .PCSrc(PCSrc),
    .cacheHit(cacheHit), .readDataOut(readDataOut), .ALUResultOut(ALUResultOut),
    .writeRegOut(writeRegOut), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_rd(input int w);
    if (mem_model.exists(w)) return mem_model[w];
    return 32'(w) * 32'h9E37_79B1 + 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    ALUResult = 32'h0; readData2 = 32'h0; writeReg = 5'd0;
    MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; RegWrite = 1'b0;
    MemToReg = 1'b0; zeroFlag = 1'b0;
  endtask

  // One EX/MEM instruction from presentation to its MEM/WB result.
  // Called just after a rising edge; returns just after the capture edge.
  // d = cycle (after the request cycle) in which memory acknowledges.
  task automatic access(input bit rd_en, input bit wr_en, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input bit rw,
                        input bit m2r, input bit br, input bit zf, input int d);
    bit is_acc, is_wr, is_rd, exp_hit;
    int word, idx;
    logic [31:0] exp_load;
    is_wr = wr_en;
    is_rd = rd_en && !wr_en;
    is_acc = rd_en || wr_en;
    word = int'(addr >> 2);
    idx = int'(addr[5:2]);
    exp_hit = is_acc && (res_word[idx] == word);
    ALUResult = addr; readData2 = wdata; writeReg = rd;
    MemRead = rd_en; MemWrite = wr_en; RegWrite = rw; MemToReg = m2r;
    Branch = br; zeroFlag = zf;
    #1;
    chk("cacheHit", {31'h0, cacheHit}, {31'h0, exp_hit});
    if (!is_acc || (is_rd && exp_hit)) begin
      chk("stall_fast", {31'h0, stall}, 32'h0);
      chk("memReq_fast", {31'h0, memReq}, 32'h0);
      chk("PCSrc_fast", {31'h0, PCSrc}, {31'h0, br & zf});
      exp_load = is_rd ? mem_rd(word) : 32'h0;
    end else begin
      chk("stall_req", {31'h0, stall}, 32'h1);
      chk("memReq_req", {31'h0, memReq}, 32'h1);
      chk("memWe_req", {31'h0, memWe}, {31'h0, is_wr});
      chk("memAddr", memAddr, {addr[31:2], 2'b00});
      if (is_wr) chk("memWData", memWData, wdata);
      chk("PCSrc_stall", {31'h0, PCSrc}, 32'h0);
      for (int c = 1; c <= d; c++) begin
        @(posedge clock);
        #1;
        if (c == d) begin
          memAck = 1'b1;
          memRData = is_wr ? $urandom : mem_rd(word);
        end
        chk("stall_wait", {31'h0, stall}, 32'h1);
        chk("memReq_wait", {31'h0, memReq}, 32'h1);
        chk("memWe_wait", {31'h0, memWe}, {31'h0, is_wr});
        chk("bubble_rw", {31'h0, RegWriteOut}, 32'h0);
        chk("bubble_m2r", {31'h0, MemToRegOut}, 32'h0);
        chk("PCSrc_wait", {31'h0, PCSrc}, 32'h0);
      end
      if (is_wr) mem_model[word] = wdata;
      else res_word[idx] = word;
      exp_load = is_rd ? mem_rd(word) : 32'h0;
      @(posedge clock);
      #1;
      memAck = 1'b0;
      memRData = $urandom;
      chk("stall_done", {31'h0, stall}, 32'h0);
      chk("memReq_done", {31'h0, memReq}, 32'h0);
      chk("PCSrc_done", {31'h0, PCSrc}, {31'h0, br & zf});
    end
    @(posedge clock);
    #1;
    if (is_rd) chk("readDataOut", readDataOut, exp_load);
    chk("ALUResultOut", ALUResultOut, addr);
    chk("writeRegOut", {27'h0, writeRegOut}, {27'h0, rd});
    chk("RegWriteOut", {31'h0, RegWriteOut}, {31'h0, rw});
    chk("MemToRegOut", {31'h0, MemToRegOut}, {31'h0, m2r});
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) res_word[i] = -1;
    mem_model[32'h40 >> 2] = 32'hDEAD_BEEF;
    drive_idle();
    memAck = 1'b0;
    memRData = 32'h0;

    // Reset
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_readDataOut", readDataOut, 32'h0);
    chk("rst_ALUResultOut", ALUResultOut, 32'h0);
    chk("rst_RegWriteOut", {31'h0, RegWriteOut}, 32'h0);
    chk("rst_memReq", {31'h0, memReq}, 32'h0);
    chk("rst_state_idle", {30'h0, dbg_state}, 32'h0);
    reset = 1'b0;

    // Directed: miss fill, hit, write hit, write miss without allocate
    access(1, 0, 32'h40, 32'h0, 5'd3, 1, 1, 0, 0, 2);
    access(1, 0, 32'h40, 32'h0, 5'd4, 1, 1, 0, 0, 1);
    access(0, 1, 32'h40, 32'h1234_5678, 5'd0, 0, 0, 0, 0, 1);
    access(1, 0, 32'h40, 32'h0, 5'd5, 1, 1, 0, 0, 1);
    access(0, 1, 32'h80, 32'hAAAA_5555, 5'd0, 0, 0, 0, 0, 1);
    access(1, 0, 32'h40, 32'h0, 5'd6, 1, 1, 0, 0, 1);
    access(1, 0, 32'h80, 32'h0, 5'd7, 1, 1, 0, 0, 3);
    access(1, 1, 32'h84, 32'h0BAD_F00D, 5'd8, 1, 0, 0, 0, 2);

    // Branch resolution alone and during a fill stall
    access(0, 0, 32'h0000_0010, 32'h0, 5'd0, 0, 0, 1, 1, 1);
    access(0, 0, 32'h0000_0014, 32'h0, 5'd0, 0, 0, 1, 0, 1);
    access(1, 0, 32'h0000_00C4, 32'h0, 5'd9, 1, 1, 1, 1, 2);

    // Randomized stream over a small address pool to force hits and conflicts
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
          | 32'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      access(kind >= 2 && kind <= 5 || kind == 9, kind >= 6, a, $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 4));
    end

    // Reset in the middle of a fill; a late ack must be ignored
    access(1, 0, 32'h40, 32'h0, 5'd1, 1, 1, 0, 0, 1);
    ALUResult = 32'h3C4; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1;
    writeReg = 5'd2; Branch = 1'b0; zeroFlag = 1'b0;
    #1;
    chk("mid_memReq", {31'h0, memReq}, 32'h1);
    @(posedge clock);
    #1;
    chk("mid_fill_memReq", {31'h0, memReq}, 32'h1);
    reset = 1'b1;
    drive_idle();
    @(posedge clock);
    #1;
    reset = 1'b0;
    memAck = 1'b1;
    memRData = 32'hFFFF_0000;
    #1;
    chk("rst2_memReq", {31'h0, memReq}, 32'h0);
    chk("rst2_stall", {31'h0, stall}, 32'h0);
    chk("rst2_readDataOut", readDataOut, 32'h0);
    chk("rst2_writeRegOut", {27'h0, writeRegOut}, 32'h0);
    chk("rst2_RegWriteOut", {31'h0, RegWriteOut}, 32'h0);
    @(posedge clock);
    #1;
    memAck = 1'b0;
    chk("rst2_ack_ignored", {31'h0, memReq}, 32'h0);
    chk("rst2_no_capture_rw", {31'h0, RegWriteOut}, 32'h0);
    for (int i = 0; i < 16; i++) res_word[i] = -1;
    access(1, 0, 32'h40, 32'h0, 5'd11, 1, 1, 0, 0, 1);
    access(1, 0, 32'h40, 32'h0, 5'd12, 1, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
